poly_mau_wb: RTL
================

POLY_MAU_WB -- requirements
Module: poly_mau_wb

Interface
REQ-001 SHALL have parameter COEF_W, default 24, the coefficient width.
REQ-002 SHALL have parameter ADDR_W, default 8, the RAM address width.
REQ-003 SHALL have parameter N_COEF, default 256, the coefficients per polynomial.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the result buffer depth (power of 2).
REQ-005 Ports SHALL be: clk input 1 (sole clock, rising edge).
REQ-006 rst input 1: asynchronous, active-high reset.
REQ-007 start input 1: one-cycle pulse that begins one polynomial writeback.
REQ-008 dual_out input 1: 1 = write both o0 and o1 per result; 0 = o0 only. Sampled at start.
REQ-009 base_addr input ADDR_W: first RAM address. Sampled at start.
REQ-010 poly_q input COEF_W: modulus, used by range check.
REQ-011 poly_valid input 1: MAU result strobe; no backpressure toward the MAU.
REQ-012 poly_mau_o0 input COEF_W and poly_mau_o1 input COEF_W: MAU results.
REQ-013 ram_we output 1, ram_addr output ADDR_W, ram_wdata output COEF_W: write request.
REQ-014 ram_ready input 1: the write is accepted on a cycle where ram_we and ram_ready are both 1.
REQ-015 busy output 1, done output 1 (one-cycle pulse), err_ovf output 1 (sticky), err_range output 1 (sticky).

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on start.
- RUN to DRAIN when N_COEF words have been pushed.
- DRAIN to DONE when the accepted count equals N_COEF.
- DONE to IDLE after one cycle.
REQ-017 start SHALL clear the counters, err_ovf and err_range, and latch base_addr and dual_out; start outside IDLE SHALL be ignored.
REQ-018 In RUN, poly_valid SHALL push the pair {o1,o0} into the FIFO; poly_valid in IDLE, DRAIN or DONE SHALL be ignored.
REQ-019 Push into a full FIFO with no simultaneous pop SHALL drop the pair and set err_ovf; a simultaneous push and pop on a full FIFO SHALL succeed.
REQ-020 ram_we SHALL be 1 whenever the output register holds a word; ram_addr, ram_wdata and ram_we SHALL stay stable until accepted.
REQ-021 When dual_out=1, each pair SHALL emit o0 at addr k, then o1 at addr k+1; the pair SHALL be popped after o1 is accepted.
REQ-022 ram_addr SHALL equal base_addr + accepted_count, modulo 2^ADDR_W (wrap-around allowed).
REQ-023 Latency: poly_valid at edge t with an empty pipe and ram_ready=1 SHALL give ram_we=1 after edge t+1.
REQ-024 Push count SHALL count coefficients: 1 per pair, or 2 when dual_out=1.
REQ-025 Writes SHALL sustain 1 word/cycle with ram_ready held high.
REQ-026 busy SHALL be 1 in RUN and DRAIN; done SHALL pulse in DONE.
REQ-027 Dropped pairs SHALL still advance the push count, so a run always terminates.

Reset
REQ-028 rst SHALL force IDLE and empty the FIFO and output register.
REQ-029 rst SHALL zero all outputs: ram_we, ram_addr, ram_wdata, busy, done, err_ovf, err_range.
REQ-030 rst asserted mid-run SHALL abort the run without completing pending writes.

Configuration
REQ-031 With POLY_WB_RANGE_CHK_EN defined, each pushed coefficient >= poly_q SHALL set err_range, and the data SHALL still be written unchanged.
REQ-032 Without POLY_WB_RANGE_CHK_EN, there SHALL be no comparator logic and err_range SHALL be tied to 0.

Structure
REQ-033 The package poly_wb_pkg SHALL hold the FSM state enum, default widths and N_COEF.
REQ-034 There SHALL be one sub-module, poly_wb_fifo, a synchronous FIFO with full/empty flags and simultaneous push/pop.

Verification
REQ-035 Single mode: base=0, dual_out=0, ram_ready=1, 256 consecutive valids with o0=1..256 -> addr 0..255 gets data 1..256, done pulses once, no errors.
REQ-036 Dual mode: dual_out=1, base=0x10, 128 valids with o0=2i, o1=2i+1 -> addr 0x10+k gets k, 256 writes; addr wraps past 0xFF.
REQ-037 Overflow: ram_ready=0 for 10 cycles during 6 consecutive valids -> 4 pairs buffered, 2 dropped, err_ovf=1, run still terminates with done.
REQ-038 Range check with macro on: q=3329, o0=3329 -> err_range=1 and 3329 written; with macro off -> err_range=0.
REQ-039 Reset mid-run: rst after 100 writes -> all outputs 0 and busy=0; a new start then runs cleanly from base.
REQ-040 Backpressure: ram_ready toggling 1010... -> the stable-hold rule is never violated and every value is written once, in order.

Source files
------------

// File: rtl/poly_wb_pkg.sv
// poly_wb_pkg: shared types and default sizes for the polynomial RAM writeback block.
//   wb_state_e       : writeback FSM state encoding
//   POLY_*           : default coefficient width, RAM address width, coefficients
//                      per polynomial and result buffer depth
package poly_wb_pkg;

    localparam int unsigned POLY_COEF_W     = 24;
    localparam int unsigned POLY_ADDR_W     = 8;
    localparam int unsigned POLY_N_COEF     = 256;
    localparam int unsigned POLY_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/poly_wb_fifo.sv
// poly_wb_fifo: synchronous FIFO with simultaneous push/pop (push into a full FIFO
// succeeds when a pop happens in the same cycle).
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   : write request and data
//   pop           : remove the head entry
//   rdata_c       : head entry (combinational read)
//   rdata_nxt_c   : entry behind the head (combinational read)
//   full, empty   : occupancy flags
//   two           : at least two entries held
// DEPTH must be a power of two, at least 2.
module poly_wb_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic [WIDTH-1:0] rdata_nxt_c,
    output logic             full,
    output logic             empty,
    output logic             two
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             two_q, two_d;
    logic             do_push, do_pop;

    // Pointer, count and flag update; flags are registered from the next count.
    always_comb begin
        do_pop     = pop & ~empty_q;
        do_push    = push & (~full_q | do_pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_nxt;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
        two_d   = (cnt_d >= CNT_W'(2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            two_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            two_q    <= two_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_c     = mem_q[rd_ptr_q];
    assign rdata_nxt_c = mem_q[rd_ptr_nxt];
    assign full        = full_q;
    assign empty       = empty_q;
    assign two         = two_q;

endmodule

// File: rtl/poly_mau_wb.sv
// poly_mau_wb: writes one polynomial of MAU results (N_COEF coefficients) into RAM.
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : pulse, begins a writeback (ignored unless idle)
//   dual_out                 : 1 = write o0 and o1 per result, 0 = o0 only (sampled at start)
//   base_addr                : first RAM address (sampled at start)
//   poly_q                   : modulus for the optional range check
//   poly_valid, poly_mau_o0/1: MAU result strobe and data, no backpressure
//   ram_we/addr/wdata        : RAM write request, held stable until ram_ready
//   ram_ready                : RAM accepts the write this cycle
//   busy, done               : run in progress, one-cycle completion pulse
//   err_ovf, err_range       : sticky result-drop and out-of-range flags
// Build option: define POLY_WB_RANGE_CHK_EN to flag pushed coefficients >= poly_q.
module poly_mau_wb
    import poly_wb_pkg::*;
#(
    parameter int unsigned COEF_W     = POLY_COEF_W,
    parameter int unsigned ADDR_W     = POLY_ADDR_W,
    parameter int unsigned N_COEF     = POLY_N_COEF,
    parameter int unsigned FIFO_DEPTH = POLY_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dual_out,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [COEF_W-1:0] poly_q,
    input  logic              poly_valid,
    input  logic [COEF_W-1:0] poly_mau_o0,
    input  logic [COEF_W-1:0] poly_mau_o1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [COEF_W-1:0] ram_wdata,
    input  logic              ram_ready,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_range
);

    localparam int unsigned CNT_W  = $clog2(N_COEF + 2);
    localparam int unsigned PAIR_W = 2 * COEF_W;

    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  push_cnt_q, push_cnt_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              dual_q, dual_d;
    logic              half_q, half_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [COEF_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_range_q, err_range_d;

    logic              accept, push_req, fifo_push, fifo_pop;
    logic [CNT_W-1:0]  push_inc;
    logic [PAIR_W-1:0] fifo_head, fifo_nxt;
    logic              fifo_full, fifo_empty, fifo_two;
    logic              unused_nxt;

    // Pairs stay in the FIFO until their last word is accepted; the output
    // register only holds a copy of the word currently offered to the RAM.
    poly_wb_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .wdata       ({poly_mau_o1, poly_mau_o0}),
        .pop         (fifo_pop),
        .rdata_c     (fifo_head),
        .rdata_nxt_c (fifo_nxt),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .two         (fifo_two)
    );

    assign unused_nxt = ^fifo_nxt[PAIR_W-1:COEF_W];

    // Next-state, counters, output register and error flags.
    always_comb begin
        state_d     = state_q;
        push_cnt_d  = push_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        base_d      = base_q;
        dual_d      = dual_q;
        half_d      = half_q;
        ram_we_d    = ram_we_q;
        ram_wdata_d = ram_wdata_q;
        err_ovf_d   = err_ovf_q;
        err_range_d = err_range_q;

        accept    = ram_we_q & ram_ready;
        fifo_pop  = accept & (~dual_q | half_q);
        push_req  = (state_q == RUN) & poly_valid;
        fifo_push = push_req & (~fifo_full | fifo_pop);
        push_inc  = dual_q ? CNT_W'(2) : CNT_W'(1);

        if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        // Reload the output register when it is empty or its word leaves this cycle.
        if (!ram_we_q || accept) begin
            ram_we_d = 1'b0;
            if (accept && dual_q && !half_q) begin
                ram_we_d    = 1'b1;
                ram_wdata_d = fifo_head[PAIR_W-1:COEF_W];
                half_d      = 1'b1;
            end else if (accept) begin
                // Head is popped now, so the next word comes from the entry behind it.
                half_d = 1'b0;
                if (fifo_two) begin
                    ram_we_d    = 1'b1;
                    ram_wdata_d = fifo_nxt[COEF_W-1:0];
                end
            end else if (!fifo_empty) begin
                ram_we_d    = 1'b1;
                ram_wdata_d = fifo_head[COEF_W-1:0];
                half_d      = 1'b0;
            end
        end

        if (push_req && fifo_full && !fifo_pop) begin
            err_ovf_d = 1'b1;
        end

`ifdef POLY_WB_RANGE_CHK_EN
        if (fifo_push && ((poly_mau_o0 >= poly_q) || (dual_q && (poly_mau_o1 >= poly_q)))) begin
            err_range_d = 1'b1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    push_cnt_d  = '0;
                    acc_cnt_d   = '0;
                    half_d      = 1'b0;
                    err_ovf_d   = 1'b0;
                    err_range_d = 1'b0;
                    base_d      = base_addr;
                    dual_d      = dual_out;
                end
            end
            RUN: begin
                // Dropped pairs still count, so the run always reaches DRAIN.
                if (poly_valid) begin
                    push_cnt_d = push_cnt_q + push_inc;
                    if (push_cnt_d >= CNT_W'(N_COEF)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // An empty pipe also ends the run when pairs were dropped.
                if ((acc_cnt_q == CNT_W'(N_COEF)) || (fifo_empty && !ram_we_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ram_addr_d = base_d + ADDR_W'(acc_cnt_d);
        busy_d     = (state_d == RUN) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            push_cnt_q  <= '0;
            acc_cnt_q   <= '0;
            base_q      <= '0;
            dual_q      <= 1'b0;
            half_q      <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            push_cnt_q  <= push_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            base_q      <= base_d;
            dual_q      <= dual_d;
            half_q      <= half_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_ovf_q   <= err_ovf_d;
            err_range_q <= err_range_d;
        end
    end

`ifndef POLY_WB_RANGE_CHK_EN
    logic unused_range;
    assign unused_range = ^poly_q;
`endif

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_ovf   = err_ovf_q;
    assign err_range = err_range_q;

endmodule
